vc_circular_buffer: RTL



---
 rtl/vc_circular_buffer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/vc_circular_buffer.sv
// vc_circular_buffer: NUM_VC independent circular FIFOs sharing one write port
// and one show-ahead read port. Each VC has an occupancy count, on/off flow
// control with hysteresis, and sticky overflow/underflow flags.
// BUFFER_SIZE may be any value >= 2, not only a power of two.
// Optional feature macro: VC_BUFFER_BYPASS_EN. When it is defined, a write and
// a read to the same empty VC in one cycle pass the flit straight from
// wr_data_i to rd_data_o, and the flit is not stored.
module vc_circular_buffer #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_VC        = 4,
    parameter int BUFFER_SIZE   = 8,
    parameter int ON_THRESHOLD  = 2,
    parameter int OFF_THRESHOLD = 2,
    parameter int VC_W          = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    parameter int CNT_W         = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en_i,
    input  logic [VC_W-1:0]         wr_vc_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic                    rd_en_i,
    input  logic [VC_W-1:0]         rd_vc_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic [NUM_VC-1:0]       empty_o,
    output logic [NUM_VC-1:0]       full_o,
    output logic [NUM_VC-1:0]       on_off_o,
    output logic [NUM_VC*CNT_W-1:0] count_o,
    output logic                    overflow_err_o,
    output logic                    underflow_err_o,
    input  logic                    err_clr_i
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);

    // Parameter sanity checks, evaluated at elaboration
    if (BUFFER_SIZE < 2) begin : g_chk_size
        $error("vc_circular_buffer: BUFFER_SIZE must be >= 2");
    end
    if (NUM_VC < 1) begin : g_chk_vc
        $error("vc_circular_buffer: NUM_VC must be >= 1");
    end
    if (ON_THRESHOLD > BUFFER_SIZE - OFF_THRESHOLD) begin : g_chk_thr
        $error("vc_circular_buffer: ON_THRESHOLD exceeds BUFFER_SIZE-OFF_THRESHOLD");
    end

    logic [DATA_WIDTH-1:0] mem_q [NUM_VC][BUFFER_SIZE];

    logic [PTR_W-1:0] wr_ptr_q [NUM_VC];
    logic [PTR_W-1:0] wr_ptr_d [NUM_VC];
    logic [PTR_W-1:0] rd_ptr_q [NUM_VC];
    logic [PTR_W-1:0] rd_ptr_d [NUM_VC];
    logic [CNT_W-1:0] cnt_q    [NUM_VC];
    logic [CNT_W-1:0] cnt_d    [NUM_VC];

    logic [NUM_VC-1:0] on_off_q;
    logic [NUM_VC-1:0] on_off_d;
    logic [NUM_VC-1:0] empty_w;
    logic [NUM_VC-1:0] full_w;

    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    logic            wr_vc_ok, rd_vc_ok;
    logic [VC_W-1:0] wr_idx, rd_idx;
    logic            same_vc;
    logic            rd_acc, wr_acc;
    logic            wr_store;
    logic            bypass;
    logic            ovf_set, unf_set;

    // Wrapping increment that also works for non-power-of-two depths
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUFFER_SIZE - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Per-VC status decoded from the registered counts
    for (genvar g = 0; g < NUM_VC; g++) begin : g_status
        assign empty_w[g]                 = (cnt_q[g] == '0);
        assign full_w[g]                  = (cnt_q[g] == CNT_W'(BUFFER_SIZE));
        assign count_o[g*CNT_W +: CNT_W]  = cnt_q[g];
    end

    assign empty_o         = empty_w;
    assign full_o          = full_w;
    assign on_off_o        = on_off_q;
    assign overflow_err_o  = ovf_q;
    assign underflow_err_o = unf_q;

    // Accept decisions; out-of-range VC numbers are clamped to VC 0 for
    // indexing only and are always rejected
    always_comb begin
        wr_vc_ok = (int'(wr_vc_i) < NUM_VC);
        rd_vc_ok = (int'(rd_vc_i) < NUM_VC);
        wr_idx   = wr_vc_ok ? wr_vc_i : '0;
        rd_idx   = rd_vc_ok ? rd_vc_i : '0;
        same_vc  = (wr_vc_i == rd_vc_i);
        rd_acc   = rd_en_i & rd_vc_ok & ~empty_w[rd_idx];
        // A full VC can take a write when the same VC is popped this cycle
        wr_acc   = wr_en_i & wr_vc_ok & (~full_w[wr_idx] | (rd_acc & same_vc));
`ifdef VC_BUFFER_BYPASS_EN
        bypass   = wr_acc & rd_en_i & rd_vc_ok & same_vc & empty_w[rd_idx];
`else
        bypass   = 1'b0;
`endif
        wr_store = wr_acc & ~bypass;
        ovf_set  = wr_en_i & ~wr_acc;
        unf_set  = rd_en_i & ~rd_acc & ~bypass;
    end

    // Show-ahead read data, or the incoming flit when it bypasses storage
    always_comb begin
        rd_data_o = mem_q[rd_idx][rd_ptr_q[rd_idx]];
        if (bypass) begin
            rd_data_o = wr_data_i;
        end
    end

    // Next pointers, counts and on/off state for every VC
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            wr_ptr_d[v] = wr_ptr_q[v];
            rd_ptr_d[v] = rd_ptr_q[v];
            cnt_d[v]    = cnt_q[v];
            on_off_d[v] = on_off_q[v];
            if (wr_store && (wr_idx == VC_W'(v))) begin
                wr_ptr_d[v] = ptr_inc(wr_ptr_q[v]);
            end
            if (rd_acc && (rd_idx == VC_W'(v))) begin
                rd_ptr_d[v] = ptr_inc(rd_ptr_q[v]);
            end
            case ({wr_store && (wr_idx == VC_W'(v)), rd_acc && (rd_idx == VC_W'(v))})
                2'b10:   cnt_d[v] = cnt_q[v] + CNT_W'(1);
                2'b01:   cnt_d[v] = cnt_q[v] - CNT_W'(1);
                default: cnt_d[v] = cnt_q[v];
            endcase
            // Hysteresis: turn on only while draining, off only while filling
            if ((cnt_d[v] < cnt_q[v]) && (int'(cnt_d[v]) < ON_THRESHOLD)) begin
                on_off_d[v] = 1'b1;
            end else if ((cnt_d[v] > cnt_q[v]) &&
                         (int'(cnt_d[v]) > BUFFER_SIZE - OFF_THRESHOLD)) begin
                on_off_d[v] = 1'b0;
            end
        end
    end

    // Sticky error flags; a new error outranks a clear in the same cycle
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (err_clr_i) begin
            ovf_d = 1'b0;
        end
        if (unf_set) begin
            unf_d = 1'b1;
        end else if (err_clr_i) begin
            unf_d = 1'b0;
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                cnt_q[v]    <= '0;
            end
            on_off_q <= '1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= wr_ptr_d[v];
                rd_ptr_q[v] <= rd_ptr_d[v];
                cnt_q[v]    <= cnt_d[v];
            end
            on_off_q <= on_off_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Flit storage, not cleared by reset; writes are ignored during reset
    always_ff @(posedge clk) begin
        if (!rst && wr_store) begin
            mem_q[wr_idx][wr_ptr_q[wr_idx]] <= wr_data_i;
        end
    end

endmodule
